// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register bank.
// Holds the FSM state encoding, the rw-bit meaning and the frame width.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    CMD,
    DATA,
    COMMIT,
    ERR
  } state_t;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_w(
    input int addr_w,
    input int data_w
  );
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses.
// Ports: clk, rst_n (sync, active low), async_i -> sync_o, rise_o, fall_o.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain clears to 0 so a pin held low through reset never
  // produces a phantom falling edge afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with a bank of NUM_REGS write/read-back registers.
// Ports: clk, rst_n, sclk, ncs, copi -> cipo, cipo_oe, regs, wr_pulse, wr_addr, frame_err.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit READ_EN     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

  logic sclk_rise;
  logic sclk_fall;
  logic sclk_s;
  logic ncs_s;
  logic ncs_rise;
  logic ncs_fall;
  logic copi_s;

  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_d;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [FRAME_W-1:0]  rx_q;
  logic [FRAME_W-1:0]  rx_d;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   tx_d;
  logic                rd_q;
  logic                rd_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                wr_pulse_q;
  logic                wr_pulse_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic                frame_err_q;
  logic                frame_err_d;

  logic                c_rw;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_data;
  logic                c_in_range;
  logic                h_rw;
  logic [ADDR_W-1:0]   h_addr;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(sclk),
    .sync_o (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ncs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(ncs),
    .sync_o (ncs_s),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  assign copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
  assign copi_s      = copi_sync_q[SYNC_STAGES-1];

  // Whole frame is in rx_q when COMMIT is reached.
  assign c_rw       = rx_q[FRAME_W-1];
  assign c_addr     = rx_q[FRAME_W-2 -: ADDR_W];
  assign c_data     = rx_q[DATA_W-1:0];
  assign c_in_range = 32'(c_addr) < NUM_REGS;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    h_rw        = 1'b0;
    h_addr      = '0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (ncs_s) state_d = IDLE;
      end
      IDLE: begin
        if (ncs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          rd_d    = 1'b0;
        end
      end
      CMD, DATA: begin
        // ncs rising wins; a coincident sclk edge is dropped.
        if (ncs_rise) begin
          if (state_q == DATA && cnt_q == CNT_FRAME)
            state_d = COMMIT;
          else
            state_d = ERR;
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[FRAME_W-2:0], copi_s};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          if (state_q == CMD && sclk_rise
              && cnt_d == CNT_CMD) begin
            h_rw    = rx_d[ADDR_W];
            h_addr  = rx_d[ADDR_W-1:0];
            state_d = DATA;
            rd_d    = READ_EN && (h_rw != RW_WRITE);
            tx_d    = '0;
            if (rd_d) begin
              for (int k = 0; k < NUM_REGS; k++)
                if (32'(h_addr) == k) tx_d = regs_q[k];
            end
          end else if (state_q == DATA && sclk_fall
                       && rd_q && cnt_q > CNT_CMD) begin
            // The fall right after the last command bit keeps
            // the MSB on the line for the first data sample.
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (c_rw == RW_WRITE) begin
          if (c_in_range) begin
            for (int k = 0; k < NUM_REGS; k++)
              if (32'(c_addr) == k) regs_d[k] = c_data;
            wr_pulse_d = 1'b1;
            wr_addr_d  = c_addr;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ERR: begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      regs_q      <= '{default: '0};
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      copi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      copi_sync_q <= copi_sync_d;
    end
  end

  always_comb begin
    regs = '0;
    for (int k = 0; k < NUM_REGS; k++)
      regs[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign cipo_oe   = (state_q == DATA) && rd_q;
  assign cipo      = cipo_oe & tx_q[DATA_W-1];
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised self-checking bench for spi_reg_bank.
// Frame-level register model plus per-cycle output compare.
module tb_spi_reg_bank;

  localparam int NR = 5;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SS = 2;
  // Negedges from the ncs pin change (driven just after a posedge)
  // to the negedge where the outcome is visible: SS+2 clk edges
  // from the pin, plus the negedge that precedes the first edge.
  localparam int LAT_NEG = SS + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic ncs = 1'b1;
  logic copi = 1'b0;
  logic cipo;
  logic cipo_oe;
  logic [NR*DW-1:0] regs;
  logic wr_pulse;
  logic [AW-1:0] wr_addr;
  logic frame_err;

  int n_tests = 0;
  int n_fail = 0;

  logic [DW-1:0] m_regs [NR];
  logic [AW-1:0] m_wr_addr;
  int pend_cnt = 0;
  int pend_kind = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;

  always #5 clk = ~clk;

  spi_reg_bank #(
    .NUM_REGS(NR),
    .ADDR_W(AW),
    .DATA_W(DW),
    .SYNC_STAGES(SS),
    .READ_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .ncs(ncs),
    .copi(copi),
    .cipo(cipo),
    .cipo_oe(cipo_oe),
    .regs(regs),
    .wr_pulse(wr_pulse),
    .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge clk) begin
    logic exp_pulse;
    logic exp_err;
    logic [NR*DW-1:0] exp_flat;
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) m_regs[k] = '0;
      m_wr_addr = '0;
      pend_cnt = 0;
      pend_kind = 0;
    end else begin
      exp_pulse = 1'b0;
      exp_err = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          if (pend_kind == 1) begin
            m_regs[int'(pend_addr)] = pend_data;
            m_wr_addr = pend_addr;
            exp_pulse = 1'b1;
          end else if (pend_kind == 2) begin
            exp_err = 1'b1;
          end
        end
      end
      for (int k = 0; k < NR; k++) exp_flat[k*DW +: DW] = m_regs[k];
      chk("regs", 64'(regs), 64'(exp_flat));
      chk("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
      chk("frame_err", 64'(frame_err), 64'(exp_err));
      chk("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    end
  end

  // One frame: bits 0..15 come from f (MSB first), extra bits random.
  // rst_at >= 0 pulses rst_n just before that bit.
  task automatic spi_frame(input logic [15:0] f, input int nbits,
                           input int rst_at,
                           output logic [DW-1:0] rd);
    logic rw;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_rd;
    int kind;
    rw = f[15];
    a = f[14:8];
    exp_rd = (!rw && int'(a) < NR) ? m_regs[int'(a)] : '0;
    rd = '0;
    ncs = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
      end
      copi = (i < 16) ? f[15-i] : 1'($urandom_range(0, 1));
      tick(8);
      if (rst_at < 0 && i >= 8 && i < 16) begin
        rd[15-i] = cipo;
        chk("cipo_oe", 64'(cipo_oe), 64'(!rw));
        if (!rw) chk("cipo", 64'(cipo), 64'(exp_rd[15-i]));
      end
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
    end
    tick(8);
    ncs = 1'b1;
    kind = 0;
    if (rst_at < 0) begin
      if (nbits != 16) kind = 2;
      else if (rw) kind = (int'(a) < NR) ? 1 : 2;
    end
    pend_kind = kind;
    pend_addr = a;
    pend_data = f[7:0];
    pend_cnt = LAT_NEG;
    tick(16);
  endtask

  initial begin
    logic [DW-1:0] rd;
    tick(5);
    rst_n = 1'b1;
    tick(10);
    chk("rst regs", 64'(regs), 64'(0));
    chk("rst cipo", 64'(cipo), 64'(0));
    chk("rst cipo_oe", 64'(cipo_oe), 64'(0));
    chk("rst wr_pulse", 64'(wr_pulse), 64'(0));
    chk("rst frame_err", 64'(frame_err), 64'(0));

    spi_frame({1'b1, 7'd0, 8'hA5}, 16, -1, rd);
    chk("t1 reg0", 64'(regs[7:0]), 64'h0A5);
    chk("t1 wr_addr", 64'(wr_addr), 64'h0);

    spi_frame({1'b1, 7'd4, 8'h80}, 16, -1, rd);
    spi_frame({1'b0, 7'd4, 8'h00}, 16, -1, rd);
    chk("t2 read", 64'(rd), 64'h080);
    chk("t2 reg4", 64'(regs[39:32]), 64'h080);

    spi_frame({1'b1, 7'd1, 8'hFF}, 10, -1, rd);
    chk("t3 reg1", 64'(regs[15:8]), 64'h0);

    spi_frame({1'b1, 7'h7F, 8'h12}, 16, -1, rd);
    chk("t4 regs", 64'(regs), 64'h80_0000_00A5);
    spi_frame({1'b0, 7'h7F, 8'h00}, 16, -1, rd);
    chk("t4 read", 64'(rd), 64'h0);

    spi_frame({1'b1, 7'd2, 8'h3C}, 17, -1, rd);
    chk("t5 reg2", 64'(regs[23:16]), 64'h0);

    spi_frame({1'b1, 7'd3, 8'h55}, 16, 5, rd);
    chk("t6 after rst", 64'(regs), 64'h0);
    spi_frame({1'b1, 7'd3, 8'h5A}, 16, -1, rd);
    chk("t6 next frame", 64'(regs), 64'h00_5A00_0000);

    for (int n = 0; n < 50; n++) begin
      int k;
      int nb;
      logic [15:0] f;
      logic [DW-1:0] d;
      k = $urandom_range(0, 9);
      d = 8'($urandom);
      nb = 16;
      case (k)
        0, 1, 2, 3: f = {1'b1, 7'($urandom_range(0, NR-1)), d};
        4: f = {1'b1, 7'($urandom_range(NR, 127)), d};
        5, 6, 7: f = {1'b0, 7'($urandom_range(0, NR+1)), d};
        8: begin
          f = 16'($urandom);
          nb = $urandom_range(0, 15);
        end
        default: begin
          f = 16'($urandom);
          nb = $urandom_range(17, 19);
        end
      endcase
      spi_frame(f, nb, -1, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
